// File: rtl/patch_fetch.sv
`timescale 1ns/1ps
// patch_fetch
//   Upstream feeder for the conv/pool stage. Takes a raster-order 8-bit
//   greyscale pixel stream, keeps the previous three image rows in line
//   buffers and emits overlapping 4x4 patches at stride 2 in both directions.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   frame_start  pulse, starts a frame (sampled in IDLE)
//   pix_valid    pixel present on pix_data
//   pix_data     unsigned 8-bit pixel, raster order
//   pix_ready    block accepts a pixel (transfer = pix_valid & pix_ready)
//   image_4x4    patch, byte (row,col) at [row*32+col*8 +: 8]
//   input_re     one-cycle strobe: image_4x4 / input_addr valid
//   input_addr   running patch index within the frame
//   busy         high while receiving a frame (FILL or STREAM)
//   frame_done   one-cycle pulse together with the final patch strobe
//
// Optional feature
//   FRAME_ABORT_EN : when defined, frame_start during FILL/STREAM aborts the
//   current frame and restarts reception from pixel (0,0). When undefined,
//   frame_start outside IDLE is ignored.
module patch_fetch #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              pix_ready,
  output logic [127:0]      image_4x4,
  output logic              input_re,
  output logic [ADDR_W-1:0] input_addr,
  output logic              busy,
  output logic              frame_done
);

  localparam int DATA_W = 8;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int OW     = IMG_W / 2 - 1;
  localparam int OH     = IMG_H / 2 - 1;

  localparam logic [CW-1:0]     COL_LAST   = CW'(IMG_W - 1);
  localparam logic [CW-1:0]     COL_MIN    = CW'(3);
  localparam logic [RW-1:0]     ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [RW-1:0]     ROW_FILL   = RW'(2);
  localparam logic [RW-1:0]     ROW_MIN    = RW'(3);
  localparam logic [ADDR_W-1:0] PATCH_LAST = ADDR_W'(OW * OH - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [1:0]          slot;       // line-buffer slot holding row r-3 (= r mod 3)
  logic [1:0]          slot_mid;   // slot holding row r-2
  logic [1:0]          slot_bot;   // slot holding row r-1
  logic [ADDR_W-1:0]   patch_cnt;
  logic                active;
  logic                xfer;
  logic                abort;
  logic                start;
  logic                emit;
  logic                row_end;

  logic [DATA_W-1:0]   lb [3][IMG_W];
  logic [127:0]        win_p0;
  logic [127:0]        win_nxt;
  logic                vld_p1;
  logic                done_p1;

  assign active    = (state == FILL) || (state == STREAM);
  assign pix_ready = active;
  assign busy      = active;
  assign xfer      = pix_valid & active;
  assign start     = (state == IDLE) & frame_start;
  assign row_end   = (col == COL_LAST);

`ifdef FRAME_ABORT_EN
  assign abort = frame_start & active;
`else
  assign abort = 1'b0;
`endif

  // A transfer at odd row >= 3 and odd column >= 3 closes a stride-2 window.
  assign emit = xfer & ~abort & row[0] & (row >= ROW_MIN) & col[0] & (col >= COL_MIN);

  assign slot_mid = (slot == 2'd2) ? 2'd0 : slot + 2'd1;
  assign slot_bot = (slot == 2'd0) ? 2'd2 : slot - 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (frame_start) state_nxt = FILL;
      end
      FILL: begin
        if (abort)                                     state_nxt = FILL;
        else if (xfer && row == ROW_FILL && row_end)   state_nxt = STREAM;
      end
      STREAM: begin
        if (abort)                                     state_nxt = FILL;
        else if (xfer && row == ROW_LAST && row_end)   state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= '0;
      row       <= '0;
      slot      <= 2'd0;
      patch_cnt <= '0;
    end else if (start || abort) begin
      col       <= '0;
      row       <= '0;
      slot      <= 2'd0;
      patch_cnt <= '0;
    end else if (xfer) begin
      if (row_end) begin
        col  <= '0;
        row  <= (row == ROW_LAST) ? '0 : row + RW'(1);
        slot <= slot_mid;
      end else begin
        col <= col + CW'(1);
      end
      if (emit) patch_cnt <= patch_cnt + ADDR_W'(1);
    end
  end

  // ---- stage p0: line buffers and sliding 4x4 window ----
  always_ff @(posedge clk) begin
    if (xfer && !abort) lb[slot][col] <= pix_data;
  end

  // Window shifts left one column; the new right column is rows r-3..r-1
  // from the line buffers (read before this cycle's write) plus the pixel.
  always_comb begin
    win_nxt = win_p0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_nxt[i*32 + j*8 +: 8] = win_p0[i*32 + (j+1)*8 +: 8];
      end
    end
    win_nxt[0*32 + 24 +: 8] = lb[slot][col];
    win_nxt[1*32 + 24 +: 8] = lb[slot_mid][col];
    win_nxt[2*32 + 24 +: 8] = lb[slot_bot][col];
    win_nxt[3*32 + 24 +: 8] = pix_data;
  end

  always_ff @(posedge clk) begin
    if (xfer) win_p0 <= win_nxt;
  end

  // ---- stage p1: patch strobe and held outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1     <= 1'b0;
      done_p1    <= 1'b0;
      image_4x4  <= '0;
      input_addr <= '0;
    end else begin
      vld_p1  <= emit;
      done_p1 <= emit && (patch_cnt == PATCH_LAST);
      if (emit) begin
        image_4x4  <= win_nxt;
        input_addr <= patch_cnt;
      end
    end
  end

  assign input_re   = vld_p1;
  assign frame_done = done_p1;

endmodule

// File: doc/patch_fetch.md
Name: patch_fetch

Overview:
- Upstream feeder for the conv/pool stage.
- Accepts a raster-order 8-bit greyscale pixel stream, buffers three image rows, and assembles overlapping 4x4 patches at stride 2 in both directions.
- Each patch is presented as a 128-bit word with a one-cycle read-enable strobe and a sequential patch address. The conv/pool stage latches the patch on that strobe and produces one pooled output per patch.

Parameters:
- IMG_W, 32, image width in pixels; even, >= 4, <= 1024.
- IMG_H, 32, image height in pixels; even, >= 4.
- ADDR_W, 16, width of input_addr; must hold (IMG_W/2-1)*(IMG_H/2-1)-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- frame_start  in  1  pulse; starts a frame, sampled only in IDLE.
- pix_valid  in  1  pixel present on pix_data.
- pix_data  in  8  unsigned pixel, raster order (row 0 first, col 0 first).
- pix_ready  out  1  block can accept a pixel; transfer = pix_valid & pix_ready.
- image_4x4  out  128  patch; byte (row,col) at bits [row*32+col*8 +: 8]; row 0 = top, col 0 = left.
- input_re  out  1  one-cycle strobe, image_4x4/input_addr valid.
- input_addr  out  ADDR_W  patch index, 0 .. OW*OH-1, where OW=IMG_W/2-1 and OH=IMG_H/2-1.
- busy  out  1  high in FILL or STREAM.
- frame_done  out  1  one-cycle pulse with the final patch strobe.

Behaviour:
- Reset values: pix_ready=0, image_4x4=0, input_re=0, input_addr=0, busy=0, frame_done=0. State=IDLE. Row/col counters=0. Line-buffer contents don't-care.
- States:
  - IDLE: pix_ready=0. frame_start=1 -> FILL; counters cleared, patch counter cleared.
  - FILL: pix_ready=1. Accepts rows 0..2. On accepting pixel (2,IMG_W-1) -> STREAM.
  - STREAM: pix_ready=1. Accepts rows 3..IMG_H-1. On accepting pixel (IMG_H-1,IMG_W-1) -> DONE.
  - DONE: lasts exactly 1 cycle; pix_ready=0; -> IDLE.
- Counters: col increments per transfer and wraps at IMG_W-1 -> 0 with row+1. No transfer means no state change; pix_valid gaps are arbitrary.
- Line buffers hold the previous three rows, indexed by column. Per transfer at (r,c), the window shifts left by one column and the new rightmost column is {row r-3, r-2, r-1, pixel} at rows 0..3. The current pixel is written into the line buffer, replacing row r-3.
- Patch emission: a transfer at (r,c) with r odd, r>=3, c odd, c>=3 completes the window at top-left (r-3,c-3). On the next cycle:
  - input_re=1;
  - image_4x4 = that window;
  - input_addr = running patch count (0-based, raster order of windows).
- image_4x4 and input_addr hold until the next strobe. input_re is never high two consecutive cycles, since patch-completing columns are odd.
- Latency: 1 cycle from completing transfer to strobe. No downstream backpressure; the consumer must accept every strobe.
- frame_done=1 in the same cycle as the strobe for patch OW*OH-1 (the DONE cycle).
- frame_start outside IDLE, including the DONE cycle, is ignored. The earliest next frame_start is the cycle after frame_done.
- rst low mid-frame: all outputs go to reset values immediately; any partial frame is discarded.
- pix_data received while pix_ready=0 is ignored.

Optional Feature:
- Macro FRAME_ABORT_EN.
- Defined: frame_start in FILL or STREAM aborts the current frame. Next cycle: state=FILL, counters and patch count cleared, any pending strobe is suppressed, and no patch from the aborted frame is emitted afterwards. A pixel transfer in the abort cycle is discarded.
- Not defined: frame_start outside IDLE is ignored (base behaviour).

Test Plan:
- IMG_W=8, IMG_H=8, pix_valid held high, pixel(r,c)=r*8+c -> first strobe 1 cycle after pixel (3,3) accepted, with input_addr=0 and image_4x4=128'h1B1A1918_13121110_0B0A0908_03020100.
- Same frame -> second strobe after pixel (3,5) with input_addr=1, image_4x4=128'h1D1C1B1A_15141312_0D0C0B0A_05040302. Exactly 9 strobes total, addrs 0..8. The last strobe follows pixel (7,7) with image_4x4=128'h3F3E3D3C_37363534_2F2E2D2C_27262524 and frame_done=1 in the same cycle.
- Same frame with pix_valid randomly deasserted ~50% -> identical patch sequence and addresses; strobes only follow completing transfers; pix_ready=0 in IDLE and DONE.
- frame_start pulsed mid-STREAM (macro off) -> no effect, 9 patches as above. With FRAME_ABORT_EN -> strobes stop, and a restarted frame yields addrs 0..8 with correct data.
- rst asserted after pixel (4,2) -> all outputs 0 and busy=0 immediately. A new frame_start then yields first patch addr 0 with 128'h1B1A1918_13121110_0B0A0908_03020100.
- Back-to-back frames with frame_start the cycle after frame_done, second frame pixel=255-(r*8+c) -> second frame addrs restart at 0. First patch is 128'hE4E5E6E7_ECEDEEEF_F4F5F6F7_FCFDFEFF, with no data carried over from frame 1.
